// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and key-lookup bundle for the iterative AES-128 inverse cipher.
// The slave side is the cipher core; the master side supplies blocks and round keys.
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  modport master (
    output in_valid, ciphertext, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, plaintext, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, with round
// keys fetched from an external key-schedule store through rk_idx/rk_data.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_cipher_iter_if.slave bus
);
  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsmState_e;

  fsmState_e    fsm_q;
  logic [127:0] data_q;
  logic [3:0]   cnt_q;
  logic [127:0] shifted, subbed, keyed, mixed, data_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] mixCoef(input int i);
    case (i)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Inverse affine map first, then the field inverse computed as a^254 (0 stays 0).
  function automatic logic [7:0] invSbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] inv;
    a   = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv;
  endfunction

  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[127-8*(4*c+r) -: 8] = data_q[127-8*(4*((c+4-r)%4)+r) -: 8];
    for (int i = 0; i < 16; i++)
      subbed[8*i +: 8] = invSbox(shifted[8*i +: 8]);
    keyed = subbed ^ bus.rk_data;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          mixed[127-8*(4*c+r) -: 8] = mixed[127-8*(4*c+r) -: 8]
                                      ^ gmul(keyed[127-8*(4*c+k) -: 8], mixCoef((k+4-r)%4));
    data_d = (cnt_q != 4'd0) ? mixed : keyed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      data_q <= '0;
      cnt_q  <= LastRound;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.ciphertext ^ bus.rk_data;
            cnt_q  <= LastRound - 4'd1;
            fsm_q  <= ROUND;
          end
        end
        ROUND: begin
          data_q <= data_d;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            fsm_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_q <= IDLE;
            cnt_q <= LastRound;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so nothing can be offered while reset is held.
  assign bus.in_ready  = ~rst & (fsm_q == IDLE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.plaintext = (fsm_q == DONE) ? data_q : '0;
  assign bus.rk_idx    = (fsm_q == ROUND) ? cnt_q : LastRound;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: known FIPS-197 vectors plus random
// blocks, all compared against a byte-array AES decryption model with its own key schedule.
module tb_aes_inv_cipher_iter;
  logic clk = 1'b0;
  logic rst;

  aes_inv_cipher_iter_if bif();

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;

  logic [7:0]   sboxTab     [256];
  logic [7:0]   invTab      [256];
  logic [127:0] offerSched  [16];
  logic [127:0] flightSched [16];

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;

  always @(posedge clk) cycleCount++;

  // The key store serves the offered block's schedule while idle, and the in-flight one while busy.
  assign bif.rk_data = bif.busy ? flightSched[bif.rk_idx] : offerSched[bif.rk_idx];

  function automatic logic [7:0] gmulModel(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] roundKey(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmulModel(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0]   st   [4][4];
    logic [7:0]   tmp  [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   last;
    logic [127:0] rk;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    rk = roundKey(key, 10);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = ct[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
    for (int round = 9; round >= 0; round--) begin
      for (int r = 1; r < 4; r++)
        for (int n = 0; n < r; n++) begin
          last     = st[r][3];
          st[r][3] = st[r][2];
          st[r][2] = st[r][1];
          st[r][1] = st[r][0];
          st[r][0] = last;
        end
      rk = roundKey(key, round);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r][c] = invTab[st[r][c]] ^ rk[127-8*(4*c+r) -: 8];
      if (round != 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            tmp[r][c] = 8'h00;
            for (int k = 0; k < 4; k++)
              tmp[r][c] = tmp[r][c] ^ gmulModel(coef[(k-r+4)%4], st[k][c]);
          end
        st = tmp;
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  task automatic buildTables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTab[0] = 8'h63;
    for (int i = 0; i < 256; i++) invTab[sboxTab[i]] = 8'(i);
    for (int i = 0; i < 16; i++) begin
      offerSched[i]  = '0;
      flightSched[i] = '0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key);
    for (int n = 0; n <= 10; n++) offerSched[n] = roundKey(key, n);
    bif.ciphertext = ct;
    bif.in_valid   = 1'b1;
  endtask

  task automatic waitAccept(input string tag, output int acceptCycle);
    logic ok;
    ok          = 1'b0;
    acceptCycle = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.in_ready && bif.in_valid) begin
        stepCycle();
        for (int n = 0; n <= 10; n++) flightSched[n] = offerSched[n];
        acceptCycle = cycleCount;
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput({tag, "_accepted"}, 128'(ok), 128'd1);
  endtask

  task automatic waitResult(input string tag, input logic [127:0] expected, output int doneCycle);
    logic seen;
    seen      = 1'b0;
    doneCycle = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.out_valid) begin
        seen      = 1'b1;
        doneCycle = cycleCount;
        break;
      end
      stepCycle();
    end
    checkOutput({tag, "_out_valid"}, 128'(seen), 128'd1);
    checkOutput({tag, "_plaintext"}, bif.plaintext, expected);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, d1;
    logic [127:0] k2, c2, expPt;
    int hold;

    buildTables();
    rst            = 1'b1;
    bif.in_valid   = 1'b0;
    bif.out_ready  = 1'b0;
    bif.ciphertext = '0;
    #3;
    checkOutput("rst_out_valid", 128'(bif.out_valid), 128'd0);
    checkOutput("rst_busy",      128'(bif.busy),      128'd0);
    checkOutput("rst_plaintext", bif.plaintext,       128'd0);
    checkOutput("rst_in_ready",  128'(bif.in_ready),  128'd0);
    checkOutput("rst_rk_idx",    128'(bif.rk_idx),    128'd10);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 128'(bif.in_ready), 128'd1);

    checkOutput("model_rk10",   roundKey(C1Key, 10),      128'h13111d7fe3944a17f307a78b4d2b30c5);
    checkOutput("model_c1",     modelDecrypt(C1Ct, C1Key), C1Pt);
    checkOutput("model_appB",   modelDecrypt(BCt, BKey),   BPt);

    // FIPS-197 C.1 with round-key index and latency tracking.
    bif.out_ready = 1'b1;
    applyStimulus(C1Ct, C1Key);
    checkOutput("c1_rk_idx_idle", 128'(bif.rk_idx), 128'd10);
    waitAccept("c1", a1);
    bif.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checkOutput("c1_rk_idx_round", 128'(bif.rk_idx), 128'(9 - k));
      checkOutput("c1_early_valid",  128'(bif.out_valid), 128'd0);
      stepCycle();
    end
    checkOutput("c1_out_valid", 128'(bif.out_valid), 128'd1);
    checkOutput("c1_plaintext", bif.plaintext, C1Pt);
    checkOutput("c1_rk_idx_done", 128'(bif.rk_idx), 128'd10);
    stepCycle();
    checkOutput("c1_release_valid", 128'(bif.out_valid), 128'd0);
    checkOutput("c1_release_ready", 128'(bif.in_ready),  128'd1);

    // FIPS-197 Appendix B.
    applyStimulus(BCt, BKey);
    waitAccept("appB", a1);
    bif.in_valid = 1'b0;
    waitResult("appB", BPt, d1);
    stepCycle();

    // Backpressure: result must hold while out_ready stays low.
    bif.out_ready = 1'b0;
    applyStimulus(C1Ct, C1Key);
    waitAccept("bp", a1);
    bif.in_valid = 1'b0;
    waitResult("bp", C1Pt, d1);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("bp_hold_valid", 128'(bif.out_valid), 128'd1);
      checkOutput("bp_hold_pt",    bif.plaintext,       C1Pt);
      checkOutput("bp_hold_ready", 128'(bif.in_ready),  128'd0);
      checkOutput("bp_hold_busy",  128'(bif.busy),      128'd1);
    end
    bif.out_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_valid", 128'(bif.out_valid), 128'd0);
    checkOutput("bp_release_ready", 128'(bif.in_ready),  128'd1);

    // A second block offered mid-run must wait until the core is idle again.
    applyStimulus(C1Ct, C1Key);
    waitAccept("rej", a1);
    bif.in_valid = 1'b0;
    repeat (4) stepCycle();
    checkOutput("rej_rk_idx", 128'(bif.rk_idx), 128'd5);
    k2 = {$urandom, $urandom, $urandom, $urandom};
    c2 = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(c2, k2);
    waitResult("rej_first", C1Pt, d1);
    waitAccept("rej_second", a2);
    bif.in_valid = 1'b0;
    checkOutput("rej_accept_gap", 128'(a2 - d1), 128'd2);
    waitResult("rej_second", modelDecrypt(c2, k2), d1);
    stepCycle();

    // Asynchronous reset in the middle of a block.
    applyStimulus(C1Ct, C1Key);
    waitAccept("mrst", a1);
    bif.in_valid = 1'b0;
    repeat (4) stepCycle();
    checkOutput("mrst_rk_idx", 128'(bif.rk_idx), 128'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("mrst_out_valid", 128'(bif.out_valid), 128'd0);
    checkOutput("mrst_busy",      128'(bif.busy),      128'd0);
    checkOutput("mrst_plaintext", bif.plaintext,       128'd0);
    checkOutput("mrst_in_ready",  128'(bif.in_ready),  128'd0);
    checkOutput("mrst_rk_idx10",  128'(bif.rk_idx),    128'd10);
    stepCycle();
    rst = 1'b0;
    applyStimulus(C1Ct, C1Key);
    waitAccept("mrst_rerun", a1);
    bif.in_valid = 1'b0;
    waitResult("mrst_rerun", C1Pt, d1);
    stepCycle();

    // Back-to-back blocks with in_valid and out_ready held high.
    applyStimulus(C1Ct, C1Key);
    waitAccept("b2b_first", a1);
    applyStimulus(BCt, BKey);
    waitResult("b2b_first", C1Pt, d1);
    waitAccept("b2b_second", a2);
    bif.in_valid = 1'b0;
    checkOutput("b2b_spacing", 128'(a2 - a1), 128'd12);
    waitResult("b2b_second", BPt, d1);
    stepCycle();

    // Random keys and blocks with random output stalls.
    for (int iter = 0; iter < 6; iter++) begin
      k2    = {$urandom, $urandom, $urandom, $urandom};
      c2    = {$urandom, $urandom, $urandom, $urandom};
      expPt = modelDecrypt(c2, k2);
      hold  = $urandom_range(0, 3);
      bif.out_ready = (hold == 0);
      applyStimulus(c2, k2);
      waitAccept("rand", a1);
      bif.in_valid = 1'b0;
      waitResult("rand", expPt, d1);
      for (int i = 0; i < hold; i++) begin
        stepCycle();
        checkOutput("rand_hold_pt", bif.plaintext, expPt);
      end
      bif.out_ready = 1'b1;
      stepCycle();
      checkOutput("rand_release_valid", 128'(bif.out_valid), 128'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
